// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch input conditioner.
package sw_pkg;
  localparam int SW_WIDTH = 10;
  localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SW_DEBOUNCE_CYCLES_SIM = 4;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;
endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioner bundle: raw pins in, clean levels and edge pulses out.
interface sw_debounce_if
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_any;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_any
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_any
  );
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch line: 2-flop sync, stability counter, level and edge pulses.
// Pulse flops exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw_i,
  output logic sw_db_o,
  output logic sw_rise_o,
  output logic sw_fall_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_raw_i;
      s2_q <= s1_q;
    end
  end

  // terminal compare comes first, so the counter can never wrap
  always_comb begin
    hit   = (s2_q != db_q) && (cnt_q == TERM);
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (hit) db_d = s2_q;
      else     cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign sw_db_o = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= hit & s2_q;
      fall_q <= hit & ~s2_q;
    end
  end

  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
`else
  assign sw_rise_o = 1'b0;
  assign sw_fall_o = 1'b0;
`endif
endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH switch lines; feeds the switch PIO in_port.
// Edge pulses and sw_any are built only with SW_DEBOUNCE_EDGE_EN.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  sw_debounce_if.slave   sw
);
  logic [WIDTH-1:0] db, rise, fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .sw_raw_i (sw.sw_raw[i]),
      .sw_db_o  (db[i]),
      .sw_rise_o(rise[i]),
      .sw_fall_o(fall[i])
    );
  end

  assign sw.sw_db   = db;
  assign sw.sw_rise = rise;
  assign sw.sw_fall = fall;
  assign sw.sw_any  = |(rise | fall);
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a 4-cycle window.
// Pulse expectations follow SW_DEBOUNCE_EDGE_EN.
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int W = SW_WIDTH;
  localparam int N = SW_DEBOUNCE_CYCLES_SIM;
  localparam int LAT = N + 2;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int errors = 0;
  int checks = 0;

  sw_debounce_if #(.WIDTH(W)) sw ();

  sw_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw     (sw)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sw.sw_raw = '0;
    step(3);
    checks++;
    if (sw.sw_db !== 10'h000) begin
      errors++;
      $display("FAIL reset_db got=%h exp=000", sw.sw_db);
    end
    checks++;
    if ({sw.sw_rise, sw.sw_fall, sw.sw_any} !== 21'h0) begin
      errors++;
      $display("FAIL reset_pulse rise=%h fall=%h any=%b exp=0",
               sw.sw_rise, sw.sw_fall, sw.sw_any);
    end
    reset_n = 1'b1;
    step(2);
  endtask

  // drives val, then checks LAT edges plus one trailing edge
  task automatic run_edge(input string nm, input logic [W-1:0] val,
                          input logic [W-1:0] prev);
    logic [W-1:0] ed, er, ef;
    sw.sw_raw = val;
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1);
      ed = (k >= LAT) ? val : prev;
      er = (EDGE && k == LAT) ? (val & ~prev) : '0;
      ef = (EDGE && k == LAT) ? (prev & ~val) : '0;
      checks++;
      if (sw.sw_db !== ed || sw.sw_rise !== er || sw.sw_fall !== ef ||
          sw.sw_any !== (|(er | ef))) begin
        errors++;
        $display("FAIL %s k=%0d db=%h/%h rise=%h/%h fall=%h/%h any=%b/%b",
                 nm, k, sw.sw_db, ed, sw.sw_rise, er, sw.sw_fall, ef,
                 sw.sw_any, |(er | ef));
      end
    end
  endtask

  task automatic test_single;
    run_edge("single_rise", 10'h001, 10'h000);
    run_edge("single_fall", 10'h000, 10'h001);
  endtask

  task automatic test_glitch;
    sw.sw_raw = 10'h008;
    step(3);
    sw.sw_raw = 10'h000;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (sw.sw_db !== 10'h000 || sw.sw_rise !== 10'h000 ||
          sw.sw_fall !== 10'h000 || sw.sw_any !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d db=%h rise=%h fall=%h exp=0",
                 k, sw.sw_db, sw.sw_rise, sw.sw_fall);
      end
      step(1);
    end
  endtask

  task automatic test_bounce;
    sw.sw_raw = 10'h008; step(1);
    sw.sw_raw = 10'h000; step(1);
    sw.sw_raw = 10'h008; step(1);
    sw.sw_raw = 10'h000; step(1);
    run_edge("bounce_rise", 10'h008, 10'h000);
    run_edge("bounce_fall", 10'h000, 10'h008);
  endtask

  task automatic test_all_bits;
    run_edge("all_rise", 10'h3FF, 10'h000);
    step(2);
    run_edge("all_fall", 10'h000, 10'h3FF);
  endtask

  task automatic test_reset_mid;
    sw.sw_raw = 10'h020;
    step(4);
    reset_n = 1'b0;
    #1;
    checks++;
    if (sw.sw_db !== 10'h000 || sw.sw_rise !== 10'h000) begin
      errors++;
      $display("FAIL mid_reset_async db=%h rise=%h exp=0",
               sw.sw_db, sw.sw_rise);
    end
    step(2);
    checks++;
    if (sw.sw_db !== 10'h000 || sw.sw_any !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold db=%h any=%b exp=0",
               sw.sw_db, sw.sw_any);
    end
    reset_n = 1'b1;
    run_edge("post_reset_rise", 10'h020, 10'h000);
    run_edge("post_reset_fall", 10'h000, 10'h020);
  endtask

  initial begin
    sw.sw_raw = '0;
    reset_n = 1'b0;
    test_reset;
    test_single;
    test_glitch;
    test_bounce;
    test_all_bits;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
